mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS control FSM and the driving end of the ALU control interface. It sequences fetch/decode/execute/memory/writeback for the multi-cycle core and issues alu_control codes every cycle. It consumes the ALU zero flag for branch resolution and handshakes with memory via mem_ready. It sits between the instruction register and the shared datapath (one ALU, one memory port).

Parameters:
SINGLE_CYCLE_MEM, 0, 1 = mem_ready ignored and treated as constant 1.
STATE_W, 4, width of state register and of the state debug port.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable after ir_write
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
alu_control  out  4  AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign/zero-ext imm, 11 = imm<<2
ext_unsigned  out  1  zero-extend immediate (andi/ori/xori)
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC write enable
iord  out  1  0 = PC address, 1 = ALUOut address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal  out  1  one-cycle pulse on unsupported opcode/funct
state  out  STATE_W  current state, debug

Behaviour:
- Only the state register and a 2-bit op-class register are sequential. Outputs are combinational from state (plus zero/mem_ready where noted). Unlisted outputs are 0.
- Reset: while rst_n is low at a clock edge, state <= RESET. In RESET all outputs are 0 and alu_control = 0010. RESET -> FETCH unconditionally.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. If mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold in FETCH with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (computes branch target). Next state by opcode:
  - lw 100011 or sw 101011 -> MEMADR
  - 000000 with legal funct -> RTYPE_EX
  - addi 001000, andi 001100, ori 001101, xori 001110, slti 001010 -> IMM_EX
  - beq 000100 -> BRANCH
  - j 000010 -> JUMP
  - anything else: illegal=1, -> FETCH
- Legal funct values: add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010. Any other funct with opcode 000000 is illegal.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEMWR: iord=1, mem_write=1. Wait for mem_ready, then -> FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_control decoded from funct. -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1. -> FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10. Opcode maps to ADD/AND/OR/XOR/SLT. ext_unsigned=1 for andi/ori/xori. -> IMMWB.
- IMMWB: reg_write=1, reg_dst=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero. -> FETCH.
- JUMP: pc_src=10, pc_en=1. -> FETCH.
- Latencies from FETCH entry, with zero memory wait: lw 5, sw 4, R-type/imm 4, beq/j 3 cycles. Each cycle mem_ready is low adds one cycle.
- Strobes mem_read and mem_write are never both 1. reg_write and pc_en are never 1 outside the states listed above.
- Reset mid-instruction: the next state is RESET regardless of current state. Any pending memory access is abandoned and no write strobe is issued after that edge.
- Unused state encodings -> RESET.

Optional Feature:
BNE_EN: when defined, opcode 000101 (bne) is decoded in DECODE -> BRANCH. In BRANCH, pc_en = ~zero for bne and zero for beq; the op-class register selects which. When undefined, 000101 is illegal.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release -> state=RESET with all strobes 0, then FETCH next cycle; alu_control=0010, alu_src_b=01.
- add (opcode 0, funct 100000), mem_ready=1 -> FETCH, DECODE, RTYPE_EX (alu_control 0010), ALUWB (reg_write=1, reg_dst=1), back to FETCH; 4 cycles total.
- lw with mem_ready held low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1 and iord=1 throughout; MEMWB asserts mem_to_reg=1; total 8 cycles.
- beq: zero=1 -> pc_en=1 and pc_src=01 in BRANCH; repeat with zero=0 -> pc_en=0; alu_control=0110 in both cases.
- opcode 111111 -> illegal=1 for exactly one cycle in DECODE, no reg_write or mem_write, FETCH next. Opcode 0 with funct 000001 behaves the same.
- sw with rst_n dropped during MEMWR while mem_ready=0 -> RESET next cycle, mem_write=0, then FETCH; with BNE_EN, bne and zero=0 -> pc_en=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU control. Optional bne support is enabled with `define BNE_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned SINGLE_CYCLE_MEM = 0,
  parameter int unsigned STATE_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [3:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_unsigned,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  // Memory handshake: an access is issued by holding mem_read/mem_write high
  // in the owning state; it completes in the cycle mem_ready is sampled high.

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] OPC_LW  = 2'b00;
  localparam logic [1:0] OPC_SW  = 2'b01;
  localparam logic [1:0] OPC_BEQ = 2'b10;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [1:0] OPC_BNE = 2'b11;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = STATE_W'(0),
    S_FETCH    = STATE_W'(1),
    S_DECODE   = STATE_W'(2),
    S_MEMADR   = STATE_W'(3),
    S_MEMRD    = STATE_W'(4),
    S_MEMWB    = STATE_W'(5),
    S_MEMWR    = STATE_W'(6),
    S_RTYPE_EX = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_IMM_EX   = STATE_W'(9),
    S_IMMWB    = STATE_W'(10),
    S_BRANCH   = STATE_W'(11),
    S_JUMP     = STATE_W'(12)
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] opc_q, opc_d;
  logic       mem_rdy;
  logic [4:0] rdec;
  logic [4:0] idec;

  // {legal, alu code} for R-type funct fields.
  function automatic logic [4:0] funct_dec(input logic [5:0] fn);
    case (fn)
      F_ADD:   return {1'b1, ALU_ADD};
      F_SUB:   return {1'b1, ALU_SUB};
      F_AND:   return {1'b1, ALU_AND};
      F_OR:    return {1'b1, ALU_OR};
      F_XOR:   return {1'b1, ALU_XOR};
      F_SLT:   return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_AND};
    endcase
  endfunction

  // {ext_unsigned, alu code} for immediate-form ALU ops.
  function automatic logic [4:0] imm_dec(input logic [5:0] op);
    case (op)
      OP_ANDI: return {1'b1, ALU_AND};
      OP_ORI:  return {1'b1, ALU_OR};
      OP_XORI: return {1'b1, ALU_XOR};
      OP_SLTI: return {1'b0, ALU_SLT};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  assign mem_rdy = (SINGLE_CYCLE_MEM != 0) ? 1'b1 : mem_ready;
  assign rdec    = funct_dec(funct);
  assign idec    = imm_dec(opcode);
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      opc_q   <= OPC_LW;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    alu_control  = ALU_AND;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    ext_unsigned = 1'b0;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_RESET: begin
        alu_control = ALU_ADD;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm << 2) so BRANCH can use ALUOut.
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW: begin
            opc_d   = OPC_LW;
            state_d = S_MEMADR;
          end
          OP_SW: begin
            opc_d   = OPC_SW;
            state_d = S_MEMADR;
          end
          OP_RTYPE: begin
            if (rdec[4]) begin
              state_d = S_RTYPE_EX;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_IMM_EX;
          OP_BEQ: begin
            opc_d   = OPC_BEQ;
            state_d = S_BRANCH;
          end
`ifdef BNE_EN
          OP_BNE: begin
            opc_d   = OPC_BNE;
            state_d = S_BRANCH;
          end
`endif
          OP_J: state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opc_q == OPC_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a   = 1'b1;
        alu_control = rdec[3:0];
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_control  = idec[3:0];
        ext_unsigned = idec[4];
        state_d      = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
`ifdef BNE_EN
        pc_en       = (opc_q == OPC_BNE) ? ~zero : zero;
`else
        pc_en       = zero;
`endif
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected output
// vectors are queued by the driver and compared by a negedge monitor.
module tb_mips_multicycle_ctrl;
  localparam int W = 23;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3, S_MEMRD = 4'd4,  S_MEMWB = 4'd5;
  localparam logic [3:0] S_MEMWR = 4'd6,  S_RTYPE = 4'd7,  S_ALUWB = 4'd8;
  localparam logic [3:0] S_IMM = 4'd9,    S_IMMWB = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_unsigned;
  logic [1:0] pc_src;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_unsigned(ext_unsigned), .pc_src(pc_src),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );

  assign obs = {state, alu_control, alu_src_a, alu_src_b, ext_unsigned, pc_src,
                pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, illegal};

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               tag, act, act[22:19], exp, exp[22:19], $time);
    end
  endtask

  // Vector layout: {state, alu, a, b, ext, pc_src, pc_en, iord, mr, mw, irw, rw, rd, m2r, ill}
  function automatic logic [W-1:0] v(input logic [3:0] st, input logic [3:0] alu,
      input logic a, input logic [1:0] b, input logic ext, input logic [1:0] pcs,
      input logic pce, input logic io, input logic mr, input logic mw,
      input logic irw, input logic rw, input logic rd, input logic m2r, input logic ill);
    return {st, alu, a, b, ext, pcs, pce, io, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  function automatic logic [W-1:0] e_reset();
    return v(S_RESET, 4'b0010, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_fetch(input logic rdy);
    return v(S_FETCH, 4'b0010, 0, 2'b01, 0, 2'b00, rdy, 0, 1, 0, rdy, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_decode(input logic ill);
    return v(S_DECODE, 4'b0010, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, ill);
  endfunction
  function automatic logic [W-1:0] e_memadr();
    return v(S_MEMADR, 4'b0010, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_memrd();
    return v(S_MEMRD, 4'b0000, 0, 2'b00, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_memwb();
    return v(S_MEMWB, 4'b0000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_memwr();
    return v(S_MEMWR, 4'b0000, 0, 2'b00, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_rtype(input logic [3:0] alu);
    return v(S_RTYPE, alu, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_aluwb();
    return v(S_ALUWB, 4'b0000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_imm(input logic [3:0] alu, input logic ext);
    return v(S_IMM, alu, 1, 2'b10, ext, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_immwb();
    return v(S_IMMWB, 4'b0000, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_branch(input logic pce);
    return v(S_BRANCH, 4'b0110, 1, 2'b00, 0, 2'b01, pce, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_jump();
    return v(S_JUMP, 4'b0000, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq("cycle", obs, exp_q.pop_front());
  end

  task automatic drive(input logic [W-1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ready();
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fstall, input int mstall);
    logic [3:0] alu;
    logic       legal_r;
    opcode = op;
    funct  = fn;
    zero   = z;
    repeat (fstall) begin mem_ready = 1'b0; drive(e_fetch(1'b0)); end
    mem_ready = 1'b1;
    drive(e_fetch(1'b1));
    rand_ready();
    case (op)
      6'b100011: begin
        drive(e_decode(1'b0)); drive(e_memadr());
        repeat (mstall) begin mem_ready = 1'b0; drive(e_memrd()); end
        mem_ready = 1'b1; drive(e_memrd());
        rand_ready(); drive(e_memwb());
      end
      6'b101011: begin
        drive(e_decode(1'b0)); drive(e_memadr());
        repeat (mstall) begin mem_ready = 1'b0; drive(e_memwr()); end
        mem_ready = 1'b1; drive(e_memwr());
      end
      6'b000000: begin
        legal_r = 1'b1;
        case (fn)
          6'b100000: alu = 4'b0010;
          6'b100010: alu = 4'b0110;
          6'b100100: alu = 4'b0000;
          6'b100101: alu = 4'b0001;
          6'b100110: alu = 4'b0011;
          6'b101010: alu = 4'b0111;
          default: begin alu = 4'b0000; legal_r = 1'b0; end
        endcase
        drive(e_decode(~legal_r));
        if (legal_r) begin drive(e_rtype(alu)); drive(e_aluwb()); end
      end
      6'b001000: begin drive(e_decode(1'b0)); drive(e_imm(4'b0010, 1'b0)); drive(e_immwb()); end
      6'b001100: begin drive(e_decode(1'b0)); drive(e_imm(4'b0000, 1'b1)); drive(e_immwb()); end
      6'b001101: begin drive(e_decode(1'b0)); drive(e_imm(4'b0001, 1'b1)); drive(e_immwb()); end
      6'b001110: begin drive(e_decode(1'b0)); drive(e_imm(4'b0011, 1'b1)); drive(e_immwb()); end
      6'b001010: begin drive(e_decode(1'b0)); drive(e_imm(4'b0111, 1'b0)); drive(e_immwb()); end
      6'b000100: begin drive(e_decode(1'b0)); drive(e_branch(z)); end
`ifdef BNE_EN
      6'b000101: begin drive(e_decode(1'b0)); drive(e_branch(~z)); end
`endif
      6'b000010: begin drive(e_decode(1'b0)); drive(e_jump()); end
      default:   drive(e_decode(1'b1));
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[12];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b000100, 6'b000010, 6'b000101, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    // Reset held two cycles, then released: one RESET cycle, then FETCH.
    @(posedge clk); #1;
    drive(e_reset());
    drive(e_reset());
    rst_n = 1'b1;
    drive(e_reset());

    // All R-type functs, all immediate ops, no stalls.
    foreach (fns[i]) run_instr(6'b000000, fns[i], 1'b0, 0, 0);
    for (int i = 3; i < 8; i++) run_instr(ops[i], 6'b000000, 1'b0, 0, 0);

    // lw with three MEMRD wait cycles, sw with none, fetch stall before j.
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000010, 6'b000000, 1'b0, 2, 0);

    // beq taken and not taken; bne both ways.
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);

    // Illegal opcode and illegal funct.
    run_instr(6'b111111, 6'b100000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0);

    // sw interrupted by reset while MEMWR is still waiting.
    opcode = 6'b101011; funct = '0; zero = 1'b0;
    mem_ready = 1'b1; drive(e_fetch(1'b1));
    drive(e_decode(1'b0));
    drive(e_memadr());
    mem_ready = 1'b0; drive(e_memwr());
    rst_n = 1'b0; drive(e_memwr());
    rst_n = 1'b1; drive(e_reset());

    // Random mix with random fetch/memory stalls.
    for (int k = 0; k < 30; k++) begin
      op = ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    check_eq("queue_empty", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
